// File: rtl/llu_wb_stage_if.sv
// Bus between the LLU issue side, the writeback stage and the register-file write port.
// The master modport is the upstream/register-file side and the slave modport is the stage.
interface llu_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_dest;
  logic [2:0]        in_op;
  logic              in_setflag;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
  logic              flag_z;
  logic              flag_n;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_data, in_dest, in_op, in_setflag, flush, wb_ack,
    input  in_ready, wb_en, wb_addr, wb_data, flag_z, flag_n, count
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_op, in_setflag, flush, wb_ack,
    output in_ready, wb_en, wb_addr, wb_data, flag_z, flag_n, count
  );
endinterface

// File: rtl/llu_wb_stage.sv
// LLU writeback stage: queues LLU results in a small FIFO, drives the register-file
// write port under a valid/ack handshake, and updates the Z/N flags as each result retires.
module llu_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input logic           clk,
  input logic           rst_n,
  llu_wb_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
    logic              setflag;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rdPtr, wrPtr, rdPtrNext;
  logic [CW-1:0]     count;
  state_t            state, stateNext;
  logic [DATA_W-1:0] wbData;
  logic [ADDR_W-1:0] wbAddr;
  logic              headSetflag;
  logic              flagZ, flagN;
  logic              inReady, accept, push, retire, loadHead;
  entry_t            inEntry, loadEntry;

  assign inReady   = (count < CW'(DEPTH));
  assign accept    = bus.in_valid && inReady && !bus.flush;
  assign push      = accept && (bus.in_op != 3'b000);
  assign retire    = (state == DRIVE) && bus.wb_ack && !bus.flush;
  assign rdPtrNext = rdPtr + PW'(1);
  assign inEntry   = '{data: bus.in_data, dest: bus.in_dest, setflag: bus.in_setflag};

  always_comb begin
    stateNext = state;
    loadHead  = 1'b0;
    loadEntry = mem[rdPtr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          stateNext = DRIVE;
          loadHead  = 1'b1;
        end
      end
      DRIVE: begin
        if (retire) begin
          if (count > CW'(1)) begin
            loadHead  = 1'b1;
            loadEntry = mem[rdPtrNext];
          end else if (push) begin
            // Sole queued entry retiring while a new one lands: forward it so back-to-back acks never bubble.
            loadHead  = 1'b1;
            loadEntry = inEntry;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (bus.flush) begin
      stateNext = IDLE;
      loadHead  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      wbData      <= '0;
      wbAddr      <= '0;
      headSetflag <= 1'b0;
      flagZ       <= 1'b0;
      flagN       <= 1'b0;
    end else begin
      state <= stateNext;
      if (bus.flush) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(retire);
        if (push)   wrPtr <= wrPtr + PW'(1);
        if (retire) rdPtr <= rdPtrNext;
      end
      if (loadHead) begin
        wbData      <= loadEntry.data;
        wbAddr      <= loadEntry.dest;
        headSetflag <= loadEntry.setflag;
      end
      if (retire && headSetflag) begin
        flagZ <= (wbData == '0);
        flagN <= wbData[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inEntry;
  end

  assign bus.in_ready = inReady;
  assign bus.wb_en    = (state == DRIVE);
  assign bus.wb_addr  = wbAddr;
  assign bus.wb_data  = wbData;
  assign bus.flag_z   = flagZ;
  assign bus.flag_n   = flagN;
  assign bus.count    = count;
endmodule

// File: tb/tb_llu_wb_stage.sv
// Directed bench for llu_wb_stage: a per-cycle vector table plus hand-written stall, flush and reset sequences.
module tb_llu_wb_stage;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  llu_wb_stage_if #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) bus ();

  llu_wb_stage #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  a;
    logic [2:0]  op;
    logic        sf;
    logic        fl;
    logic        ack;
    logic        en;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        z;
    logic        n;
    logic [1:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input logic [2:0] op, input logic sf, input logic fl, input logic ack);
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_dest    = a;
    bus.in_op      = op;
    bus.in_setflag = sf;
    bus.flush      = fl;
    bus.wb_ack     = ack;
  endtask

  task automatic chkAll(input string tag, input logic en, input logic [3:0] wa, input logic [15:0] wd,
                        input logic z, input logic n, input logic [1:0] cnt, input logic rdy);
    chk({tag, ".wb_en"},    32'(bus.wb_en),    32'(en));
    chk({tag, ".wb_addr"},  32'(bus.wb_addr),  32'(wa));
    chk({tag, ".wb_data"},  32'(bus.wb_data),  32'(wd));
    chk({tag, ".flag_z"},   32'(bus.flag_z),   32'(z));
    chk({tag, ".flag_n"},   32'(bus.flag_n),   32'(n));
    chk({tag, ".count"},    32'(bus.count),    32'(cnt));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            v  data      a  op      sf fl ack | en wa  wd        z  n  cnt rdy
    vecs[0]  = '{1, 16'h00F0, 3, 3'b001, 1, 0, 1,   0, 0, 16'h0000, 0, 0, 1, 1};
    vecs[1]  = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   1, 3, 16'h00F0, 0, 0, 1, 1};
    vecs[2]  = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   0, 3, 16'h00F0, 0, 0, 0, 1};
    vecs[3]  = '{1, 16'h8000, 5, 3'b010, 1, 0, 0,   0, 3, 16'h00F0, 0, 0, 1, 1};
    vecs[4]  = '{1, 16'h0000, 6, 3'b100, 1, 0, 0,   1, 5, 16'h8000, 0, 0, 2, 0};
    vecs[5]  = '{1, 16'hFFFF, 7, 3'b001, 1, 0, 0,   1, 5, 16'h8000, 0, 0, 2, 0};
    vecs[6]  = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   1, 6, 16'h0000, 0, 1, 1, 1};
    vecs[7]  = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   0, 6, 16'h0000, 1, 0, 0, 1};
    vecs[8]  = '{1, 16'h0000, 2, 3'b000, 1, 0, 0,   0, 6, 16'h0000, 1, 0, 0, 1};
    vecs[9]  = '{0, 16'h0000, 0, 3'b000, 0, 0, 0,   0, 6, 16'h0000, 1, 0, 0, 1};
    vecs[10] = '{1, 16'h8001, 9, 3'b001, 0, 0, 1,   0, 6, 16'h0000, 1, 0, 1, 1};
    vecs[11] = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   1, 9, 16'h8001, 1, 0, 1, 1};
    vecs[12] = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   0, 9, 16'h8001, 1, 0, 0, 1};
    vecs[13] = '{1, 16'h1111, 1, 3'b001, 1, 0, 1,   0, 9, 16'h8001, 1, 0, 1, 1};
    vecs[14] = '{1, 16'h2222, 2, 3'b001, 1, 0, 1,   1, 1, 16'h1111, 1, 0, 2, 0};
    vecs[15] = '{1, 16'h3333, 3, 3'b001, 1, 0, 1,   1, 2, 16'h2222, 0, 0, 1, 1};
    vecs[16] = '{1, 16'h4444, 4, 3'b001, 1, 0, 1,   1, 4, 16'h4444, 0, 0, 1, 1};
    vecs[17] = '{0, 16'h0000, 0, 3'b000, 0, 0, 1,   0, 4, 16'h4444, 0, 0, 0, 1};

    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chkAll("reset", 0, 4'h0, 16'h0000, 0, 0, 2'd0, 1);
    rst_n = 1'b1;
    step();

    for (int unsigned i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].op, vecs[i].sf, vecs[i].fl, vecs[i].ack);
      step();
      chkAll($sformatf("vec%0d", i), vecs[i].en, vecs[i].wa, vecs[i].wd,
             vecs[i].z, vecs[i].n, vecs[i].cnt, vecs[i].rdy);
    end

    // stall stability: head held in DRIVE for five cycles without ack
    drive(1, 16'hABCD, 4'hA, 3'b001, 1, 0, 0);
    step();
    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 0);
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      chkAll($sformatf("stall%0d", i), 1, 4'hA, 16'hABCD, 0, 0, 2'd1, 1);
      step();
    end

    // flush with ack: second entry queued, then flush+ack+enqueue in one cycle
    drive(1, 16'h0000, 4'hB, 3'b001, 1, 0, 0);
    step();
    chk("flush.pre_count", 32'(bus.count), 32'd2);
    drive(1, 16'h0000, 4'hC, 3'b001, 1, 1, 1);
    step();
    chkAll("flush", 0, 4'hA, 16'hABCD, 0, 0, 2'd0, 1);
    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 0);
    step();
    chkAll("flush.after", 0, 4'hA, 16'hABCD, 0, 0, 2'd0, 1);

    // retire 8000 to set flag_n, then reset asynchronously while 5A5A is in DRIVE
    drive(1, 16'h8000, 4'h1, 3'b001, 1, 0, 1);
    step();
    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 1);
    step();
    step();
    chk("pre_reset.flag_n", 32'(bus.flag_n), 32'd1);
    drive(1, 16'h5A5A, 4'h5, 3'b001, 1, 0, 0);
    step();
    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 0);
    step();
    chk("pre_reset.wb_en", 32'(bus.wb_en), 32'd1);
    chk("pre_reset.wb_data", 32'(bus.wb_data), 32'h5A5A);
    #1;
    rst_n = 1'b0;
    #1;
    chkAll("async_reset", 0, 4'h0, 16'h0000, 0, 0, 2'd0, 1);
    #1;
    rst_n = 1'b1;
    step();
    chkAll("post_reset", 0, 4'h0, 16'h0000, 0, 0, 2'd0, 1);
    drive(1, 16'h1234, 4'h7, 3'b001, 1, 0, 0);
    step();
    drive(0, 16'h0, 4'h0, 3'b000, 0, 0, 0);
    chk("post_reset.count", 32'(bus.count), 32'd1);
    chk("post_reset.wb_en0", 32'(bus.wb_en), 32'd0);
    step();
    chkAll("post_reset.load", 1, 4'h7, 16'h1234, 0, 0, 2'd1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
